// File: rtl/uart_rx_engine_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, minimum
// bit period and a period clamp helper. The BREAK state exists only when
// UART_RX_BREAK_DETECT_EN is defined.
package uart_rx_engine_pkg;

    localparam int unsigned MIN_PERIOD = 4;

    typedef enum logic [2:0] {
        UART_RX_IDLE,
        UART_RX_START,
        UART_RX_DATA,
        UART_RX_PARITY,
        UART_RX_STOP
`ifdef UART_RX_BREAK_DETECT_EN
        , UART_RX_BREAK
`endif
    } rx_state_t;

    // Periods below the minimum cannot place a mid-bit sample; raise them.
    function automatic logic [15:0] clamp_period(input logic [15:0] p);
        return (p < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : p;
    endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Configuration and received-frame bus of the UART receiver.
// slave = receiver side, master = register/FIFO side.
// break_det is present only with UART_RX_BREAK_DETECT_EN.
interface uart_rx_engine_if #(
    parameter int unsigned MAX_DATA_BITS = 16
);
    logic [15:0]              cfg_period;
    logic [4:0]               cfg_data_bits;
    logic                     cfg_parity_en;
    logic                     cfg_parity_odd;
    logic [1:0]               cfg_stop_bits;
    logic [MAX_DATA_BITS-1:0] data;
    logic                     valid;
    logic                     parity_error;
    logic                     framing_error;
    logic                     busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                     break_det;
`endif

    modport master (
        output cfg_period, cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_stop_bits,
        input  data, valid, parity_error, framing_error, busy
`ifdef UART_RX_BREAK_DETECT_EN
        , input break_det
`endif
    );

    modport slave (
        input  cfg_period, cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_stop_bits,
        output data, valid, parity_error, framing_error, busy
`ifdef UART_RX_BREAK_DETECT_EN
        , output break_det
`endif
    );

endinterface

// File: rtl/uart_rx_engine_bit_timer.sv
// uart_bit_timer: loadable 16-bit down counter; holds at zero and flags
// tick while the count is zero. A load overrides the decrement.
module uart_bit_timer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic        o_tick
);

    logic [15:0] r_count;

    // Count down to zero and stay there until reloaded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_tick = (r_count == '0);

endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART receiver with runtime bit period, data width,
// parity and stop bits. Optional break detection under the macro
// UART_RX_BREAK_DETECT_EN (adds bus.break_det and the BREAK state).
module uart_rx_engine
    import uart_rx_engine_pkg::*;
#(
    parameter int unsigned MAX_DATA_BITS = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_enable,
    input  logic           i_rx,
    uart_rx_engine_if.slave bus
);

    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_prev_rx;
    logic                     w_rx_s;
    logic                     w_fall;
    logic                     w_start;
    rx_state_t                r_state;
    rx_state_t                w_state_next;
    logic [15:0]              r_period;
    logic [4:0]               r_data_bits;
    logic                     r_par_en;
    logic                     r_par_odd;
    logic                     r_two_stops;
    logic [4:0]               r_bit_cnt;
    logic                     r_stop_cnt;
    logic [MAX_DATA_BITS-1:0] r_shift;
    logic                     r_par_err;
    logic                     r_frm_err;
    logic [MAX_DATA_BITS-1:0] r_data;
    logic                     r_valid;
    logic                     r_perr;
    logic                     r_ferr;
    logic                     w_tick;
    logic                     w_load;
    logic [15:0]              w_load_val;
    logic                     w_done;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                     r_all_zero;
    logic                     r_brk;
    logic                     w_brk;

    assign w_brk         = r_all_zero & ~w_rx_s;
    assign bus.break_det = r_brk;
`endif

    assign w_rx_s  = r_sync[SYNC_STAGES-1];
    assign w_fall  = r_prev_rx & ~w_rx_s;
    assign w_start = (r_state == UART_RX_IDLE) && i_enable && w_fall;

    // Input synchronizer chain and previous-sample register for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= '1;
            r_prev_rx <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_prev_rx <= w_rx_s;
        end
    end

    uart_bit_timer u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tick     (w_tick)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= UART_RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, bit-timer reloads and frame completion strobe.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = r_period - 16'd1;
        w_done       = 1'b0;
        case (r_state)
            UART_RX_IDLE: begin
                if (w_start) begin
                    w_state_next = UART_RX_START;
                    w_load       = 1'b1;
                    w_load_val   = (clamp_period(bus.cfg_period) >> 1) - 16'd1;
                end
            end
            UART_RX_START: begin
                if (w_tick) begin
                    w_load       = 1'b1;
                    w_state_next = w_rx_s ? UART_RX_IDLE : UART_RX_DATA;
                end
            end
            UART_RX_DATA: begin
                if (w_tick) begin
                    w_load = 1'b1;
                    if (r_bit_cnt == r_data_bits - 5'd1) begin
                        w_state_next = r_par_en ? UART_RX_PARITY : UART_RX_STOP;
                    end
                end
            end
            UART_RX_PARITY: begin
                if (w_tick) begin
                    w_load       = 1'b1;
                    w_state_next = UART_RX_STOP;
                end
            end
            UART_RX_STOP: begin
                if (w_tick) begin
                    w_load = 1'b1;
                    if (!r_two_stops || r_stop_cnt) begin
                        w_done       = 1'b1;
                        w_state_next = UART_RX_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (w_brk) begin
                            w_state_next = UART_RX_BREAK;
                        end
`endif
                    end
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            UART_RX_BREAK: begin
                if (w_rx_s) begin
                    w_state_next = UART_RX_IDLE;
                end
            end
`endif
            default: w_state_next = UART_RX_IDLE;
        endcase
        if (!i_enable) begin
            w_state_next = UART_RX_IDLE;
            w_done       = 1'b0;
        end
    end

    // Config shadowing, bit sampling, error accumulation and output update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_period    <= 16'(MIN_PERIOD);
            r_data_bits <= 5'd1;
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_two_stops <= 1'b0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            r_all_zero  <= 1'b1;
            r_brk       <= 1'b0;
`endif
        end else begin
            r_valid <= w_done;
            if (w_start) begin
                r_period    <= clamp_period(bus.cfg_period);
                r_data_bits <= bus.cfg_data_bits;
                r_par_en    <= bus.cfg_parity_en;
                r_par_odd   <= bus.cfg_parity_odd;
                r_two_stops <= (bus.cfg_stop_bits == 2'd2);
                r_bit_cnt   <= '0;
                r_stop_cnt  <= 1'b0;
                r_shift     <= '0;
                r_par_err   <= 1'b0;
                r_frm_err   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                r_all_zero  <= 1'b1;
`endif
            end else if (w_tick) begin
                case (r_state)
                    UART_RX_DATA: begin
                        r_shift   <= r_shift | (MAX_DATA_BITS'(w_rx_s) << r_bit_cnt);
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                    UART_RX_PARITY: begin
                        r_par_err <= (w_rx_s != (r_par_odd ^ (^r_shift)));
                    end
                    UART_RX_STOP: begin
                        r_stop_cnt <= 1'b1;
                        r_frm_err  <= r_frm_err | ~w_rx_s;
                    end
                    default: ;
                endcase
`ifdef UART_RX_BREAK_DETECT_EN
                if (r_state == UART_RX_DATA || r_state == UART_RX_PARITY ||
                    r_state == UART_RX_STOP) begin
                    r_all_zero <= r_all_zero & ~w_rx_s;
                end
`endif
            end
            if (w_done) begin
                r_data <= r_shift;
                r_perr <= r_par_err;
                r_ferr <= r_frm_err | ~w_rx_s;
`ifdef UART_RX_BREAK_DETECT_EN
                r_brk  <= w_brk;
                if (w_brk) begin
                    r_data <= '0;
                end
`endif
            end
        end
    end

    assign bus.data          = r_data;
    assign bus.valid         = r_valid;
    assign bus.parity_error  = r_perr;
    assign bus.framing_error = r_ferr;
    assign bus.busy          = (r_state != UART_RX_IDLE);

endmodule
